// File: rtl/umips_pkg.sv
// umips_pkg: shared definitions for the umips multiply/divide unit.
//   MD_ITER              iterations per operation (one per operand bit)
//   MD_MULT..MD_DIVU     encodings of the 2-bit op field
//   md_state_e           sequencer states
package umips_pkg;

    localparam int MD_ITER = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/umips_muldiv_step.sv
// umips_muldiv_step: one combinational multiply or divide iteration.
//   is_div   1: restoring divide step, 0: shift-add multiply step
//   acc_in   65-bit accumulator
//              multiply: [64:32] partial product, [31:0] remaining multiplier bits
//              divide:   [64:32] partial remainder, [31:0] dividend bits / quotient
//   operand  multiplicand (multiply) or divisor (divide) magnitude
//   acc_out  accumulator after the step (divide: LSB left clear)
//   q_bit    quotient bit produced by a divide step (0 for multiply)
module umips_muldiv_step
    import umips_pkg::*;
(
    input  logic        is_div,
    input  logic [64:0] acc_in,
    input  logic [31:0] operand,
    output logic [64:0] acc_out,
    output logic        q_bit
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [33:0] diff;

    always_comb begin
        // Upper half never exceeds 32 significant bits before the add, so 33 bits hold the sum.
        sum    = acc_in[64:32] + {1'b0, operand};
        // Remainder shifted left with the next dividend bit (MSB first) shifted in.
        rem_sh = {acc_in[63:32], acc_in[31]};
        // Extra bit so the borrow shows up as a negative result.
        diff   = {1'b0, rem_sh} - {2'b00, operand};

        acc_out = acc_in;
        q_bit   = 1'b0;
        if (is_div) begin
            q_bit   = ~diff[33];
            acc_out = {(q_bit ? diff[32:0] : rem_sh), acc_in[30:0], 1'b0};
        end else if (acc_in[0]) begin
            acc_out = {1'b0, sum, acc_in[31:1]};
        end else begin
            acc_out = {1'b0, acc_in[64:1]};
        end
    end

endmodule

// File: rtl/umips_muldiv_unit.sv
// umips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//   clk, rst_n           clock, asynchronous active-low reset
//   start, op            execute-stage mul/div request and its operation
//   src_a, src_b         rs / rt operands
//   hilo_rd              decode-stage instruction reads HI or LO
//   hi_we, lo_we         MTHI / MTLO in execute, data on hilo_wdata
//   busy                 operation in progress (state != IDLE)
//   stall                stall request to the hazard unit
//   done                 one-cycle pulse when a fresh result lands in HI/LO
//   hi, lo               HI / LO registers
// Latency: start sampled in cycle 0, 32 CALC cycles, FIX in cycle 33,
// result visible with done in cycle 34.
module umips_muldiv_unit
    import umips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hilo_rd,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_reg, state_next;
    logic [5:0]  cnt_reg;
    logic [1:0]  op_reg;
    logic [64:0] acc_reg;
    logic [31:0] opnd_reg;      // multiplicand or divisor magnitude
    logic [31:0] a_raw_reg;     // src_a as issued, returned in HI on divide by zero
    logic        res_neg_reg;   // sign_a ^ sign_b for signed ops
    logic        dvd_neg_reg;   // dividend sign for signed ops
    logic        div_zero_reg;
    logic [31:0] hi_reg, lo_reg;
    logic        done_reg;

    logic        is_signed;
    logic [31:0] a_abs, b_abs;
    logic [64:0] step_acc;
    logic        step_q;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;
    logic [31:0] hi_fix, lo_fix;

    // Signed ops have op[0] clear.
    assign is_signed = ~op[0];
    assign a_abs     = (is_signed && src_a[31]) ? -src_a : src_a;
    assign b_abs     = (is_signed && src_b[31]) ? -src_b : src_b;

    umips_muldiv_step u_step (
        .is_div  (op_reg[1]),
        .acc_in  (acc_reg),
        .operand (opnd_reg),
        .acc_out (step_acc),
        .q_bit   (step_q)
    );

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MD_IDLE: if (start) state_next = MD_CALC;
            MD_CALC: if (cnt_reg == 6'(MD_ITER - 1)) state_next = MD_FIX;
            MD_FIX:  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Sign correction and special cases applied in FIX.
    always_comb begin
        prod_fix = (res_neg_reg && !op_reg[0]) ? -acc_reg[63:0] : acc_reg[63:0];
        quot_fix = (res_neg_reg && !op_reg[0]) ? -acc_reg[31:0] : acc_reg[31:0];
        rem_fix  = (dvd_neg_reg && !op_reg[0]) ? -acc_reg[63:32] : acc_reg[63:32];
        hi_fix   = prod_fix[63:32];
        lo_fix   = prod_fix[31:0];
        if (op_reg[1]) begin
            if (div_zero_reg) begin
                hi_fix = a_raw_reg;
                lo_fix = 32'hFFFF_FFFF;
            end else begin
                // 0x8000_0000 / -1 falls out naturally: quotient magnitude
                // 0x8000_0000 negates to itself, remainder is 0.
                hi_fix = rem_fix;
                lo_fix = quot_fix;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= MD_IDLE;
            cnt_reg      <= '0;
            op_reg       <= MD_MULT;
            acc_reg      <= '0;
            opnd_reg     <= '0;
            a_raw_reg    <= '0;
            res_neg_reg  <= 1'b0;
            dvd_neg_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                MD_IDLE: begin
                    if (start) begin
                        // start wins over a simultaneous MTHI/MTLO.
                        op_reg       <= op;
                        cnt_reg      <= '0;
                        opnd_reg     <= op[1] ? b_abs : a_abs;
                        acc_reg      <= {33'd0, (op[1] ? a_abs : b_abs)};
                        a_raw_reg    <= src_a;
                        res_neg_reg  <= is_signed & (src_a[31] ^ src_b[31]);
                        dvd_neg_reg  <= is_signed & src_a[31];
                        div_zero_reg <= (src_b == 32'd0);
                    end else begin
                        if (hi_we) hi_reg <= hilo_wdata;
                        if (lo_we) lo_reg <= hilo_wdata;
                    end
                end
                MD_CALC: begin
                    // Divide steps leave the LSB clear for the quotient bit.
                    acc_reg <= {step_acc[64:1], step_acc[0] | step_q};
                    cnt_reg <= cnt_reg + 6'd1;
                end
                MD_FIX: begin
                    hi_reg   <= hi_fix;
                    lo_reg   <= lo_fix;
                    done_reg <= 1'b1;
                    cnt_reg  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_reg != MD_IDLE);
    assign stall = (hilo_rd & (busy | start)) | (busy & (start | hi_we | lo_we));
    assign done  = done_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: tb/tb_umips_muldiv_unit.sv
module tb_umips_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        hilo_rd, hi_we, lo_we;
    logic [31:0] hilo_wdata;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    umips_muldiv_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .hilo_rd    (hilo_rd),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .hilo_wdata (hilo_wdata),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb, sq, sr;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin sp = longint'(sa) * longint'(sb); return sp; end
            2'b01: begin up = {32'd0, a} * {32'd0, b}; return up; end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sq = sa / sb;
                sr = sa % sb;
                return {sr, sq};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Reference model: cycles remaining until the result lands.
    int          m_cnt;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_cnt == 0) begin
                if (start) begin
                    {m_phi, m_plo} = ref_md(op, src_a, src_b);
                    m_cnt = 33;
                end else begin
                    if (hi_we) m_hi = hilo_wdata;
                    if (lo_we) m_lo = hilo_wdata;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi   = m_phi;
                    m_lo   = m_plo;
                    m_done = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic m_busy;
        m_busy = (m_cnt != 0);
        chk("busy",  64'(busy),  64'(m_busy));
        chk("stall", 64'(stall), 64'((hilo_rd & (m_busy | start)) | (m_busy & (start | hi_we | lo_we))));
        chk("done",  64'(done),  64'(m_done));
        chk("hi",    64'(hi),    64'(m_hi));
        chk("lo",    64'(lo),    64'(m_lo));
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("wait_idle_timeout", 64'(n >= 200), 64'd0);
    endtask

    // One op issued in cycle 0; checks busy length, stall span and literal result.
    task automatic directed_op(input string name, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                               input logic rd);
        int bc = 0;
        int sc = 0;
        start = 1; op = o; src_a = a; src_b = b; hilo_rd = rd;
        #1;
        if (stall) sc++;
        @(posedge clk); #2;
        start = 0;
        while (busy && bc < 100) begin
            bc++;
            if (stall) sc++;
            step();
        end
        chk({name, "_busy_cycles"}, 64'(bc), 64'd33);
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_hi"}, 64'(hi), 64'(ehi));
        chk({name, "_lo"}, 64'(lo), 64'(elo));
        if (rd) begin
            chk({name, "_stall_cycles"}, 64'(sc), 64'd34);
            chk({name, "_stall_c34"}, 64'(stall), 64'd0);
        end
        hilo_rd = 0;
        $display("op %s: hi=%h lo=%h", name, hi, lo);
        step();
    endtask

    function automatic logic [31:0] pick;
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        rst_n = 0; start = 0; op = 0; src_a = 0; src_b = 0;
        hilo_rd = 0; hi_we = 0; lo_we = 0; hilo_wdata = 0;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        step(); step();
        rst_n = 1;
        step();

        // Pin the model itself.
        chk("model_mult",  ref_md(2'b00, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
        chk("model_multu", ref_md(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("model_div",   ref_md(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_divu0", ref_md(2'b11, 32'd100, 32'd0), 64'h0000_0064_FFFF_FFFF);

        directed_op("mult_m2x3", 2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
        directed_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        directed_op("div_m7d2",  2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        directed_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        directed_op("divu_by0",  2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0);
        directed_op("div_by0",   2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);

        // MTLO in IDLE.
        lo_we = 1; hilo_wdata = 32'h1234;
        step();
        lo_we = 0;
        chk("mtlo_idle_lo", 64'(lo), 64'h1234);
        chk("mtlo_idle_done", 64'(done), 64'd0);
        $display("op mtlo: lo=%h", lo);

        // MTLO during CALC is stalled and does not write.
        start = 1; op = 2'b01; src_a = 32'd7; src_b = 32'd6;
        step();
        start = 0;
        repeat (3) step();
        lo_we = 1; hilo_wdata = 32'h5678;
        #1;
        chk("mtlo_calc_stall", 64'(stall), 64'd1);
        step(); step();
        lo_we = 0;
        chk("mtlo_calc_lo", 64'(lo), 64'h1234);
        wait_idle();
        chk("mulu_7x6_lo", 64'(lo), 64'd42);
        $display("op multu 7x6: hi=%h lo=%h", hi, lo);
        step();

        // start held through busy: second op accepted in cycle 34 only.
        start = 1; op = 2'b11; src_a = 32'd1000; src_b = 32'd7;
        step();
        wait_idle();
        chk("hold_done_c34", 64'(done), 64'd1);
        chk("hold_lo_c34", 64'(lo), 64'd142);
        step();
        chk("hold_busy_c35", 64'(busy), 64'd1);
        start = 0;
        wait_idle();
        chk("hold_second_hi", 64'(hi), 64'd6);
        $display("op divu hold: hi=%h lo=%h", hi, lo);
        step();

        // Reset in cycle 10 of a DIV.
        start = 1; op = 2'b10; src_a = 32'd12345; src_b = 32'd17;
        step();
        start = 0;
        repeat (9) step();
        rst_n = 0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hi", 64'(hi), 64'd0);
        chk("rst_mid_lo", 64'(lo), 64'd0);
        step();
        rst_n = 1;
        dones = 0;
        repeat (40) begin
            step();
            if (done) dones++;
        end
        chk("rst_mid_no_done", 64'(dones), 64'd0);
        $display("op reset mid-div: hi=%h lo=%h", hi, lo);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                hi_we = 1'($urandom_range(0, 1));
                lo_we = 1'($urandom_range(0, 1));
                hilo_wdata = $urandom;
                step();
            end
            hi_we = 0; lo_we = 0;
            start = 1; op = 2'($urandom_range(0, 3)); src_a = pick(); src_b = pick();
            hilo_rd = 1'($urandom_range(0, 1));
            $display("op rand %0d: op=%0d a=%h b=%h", t, op, src_a, src_b);
            step();
            start = 0;
            for (int c = 0; c < 8; c++) begin
                lo_we = 1'($urandom_range(0, 3) == 0);
                hi_we = 1'($urandom_range(0, 3) == 0);
                hilo_wdata = $urandom;
                step();
            end
            hi_we = 0; lo_we = 0;
            wait_idle();
            hilo_rd = 0;
        end
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
